pipeline_control_unit: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). It combines three inputs: the RAW hazard flag from decode, the taken-branch/jump redirect from EX, and the data-memory handshake from MEM. From these it drives per-stage pipeline-register enables and flushes. It owns a memory-wait FSM with timeout, a hazard-stall watchdog and a saturating stall-cycle performance counter.

---
 rtl/pipeline_control_unit.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_control_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for a 5-stage RV32I pipeline: combines RAW hazard,
// EX redirect and data-memory handshake into per-stage enables and flushes.
module pipeline_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned HAZARD_MAX  = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             hazard_detected_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_wb_flush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic             timeout_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned HAZ_W  = $clog2(HAZARD_MAX + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  state_e            state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [HAZ_W-1:0]  haz_cnt_q;
  logic [HAZ_W-1:0]  haz_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;
  logic              timeout_q;

  logic              in_error_s;
  logic              freeze_s;
  logic              branch_s;
  logic              haz_apply_s;
  logic              haz_trip_s;
  logic              wait_trip_s;
  logic [4:0]        en_s;
  logic [2:0]        flush_s;

  // Any encoding other than RUN/MEM_WAIT is treated as the absorbing error state.
  always_comb begin
    in_error_s = (state_q != ST_RUN) && (state_q != ST_MEM_WAIT);
    if (state_q == ST_RUN) begin
      freeze_s = dmem_req_i && !dmem_ack_i;
    end else if (state_q == ST_MEM_WAIT) begin
      freeze_s = !dmem_ack_i;
    end else begin
      freeze_s = 1'b0;
    end
    branch_s    = !in_error_s && !freeze_s && branch_taken_i;
    haz_apply_s = !in_error_s && !freeze_s && !branch_taken_i && hazard_detected_i;
    haz_trip_s  = haz_apply_s && (haz_cnt_q == HAZ_W'(HAZARD_MAX - 1));
    wait_trip_s = freeze_s && (state_q == ST_MEM_WAIT)
                  && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
  end

  // Hazard run length: grows on applied stalls, frozen cycles leave it alone.
  always_comb begin
    if (haz_apply_s) begin
      haz_cnt_d = haz_cnt_q + HAZ_W'(1);
    end else if (freeze_s || in_error_s) begin
      haz_cnt_d = haz_cnt_q;
    end else begin
      haz_cnt_d = {HAZ_W{1'b0}};
    end
  end

  // Enable/flush decode, priority error > freeze > branch > hazard > normal.
  always_comb begin
    en_s    = 5'b11111;
    flush_s = 3'b000;
    if (!rst_n_i) begin
      en_s    = 5'b00000;
      flush_s = 3'b111;
    end else if (in_error_s) begin
      en_s    = 5'b00000;
      flush_s = 3'b000;
    end else if (freeze_s) begin
      // WB instruction retires once; a bubble follows it while MEM is held.
      en_s    = 5'b00000;
      flush_s = 3'b001;
    end else if (branch_s) begin
      en_s    = 5'b11111;
      flush_s = 3'b110;
    end else if (haz_apply_s) begin
      en_s    = 5'b00111;
      flush_s = 3'b010;
    end else begin
      en_s    = 5'b11111;
      flush_s = 3'b000;
    end
  end

  assign {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = en_s;
  assign {if_id_flush_o, id_ex_flush_o, mem_wb_flush_o}                = flush_s;

  // Saturating stall counter next value.
  always_comb begin
    if (!en_s[4] && !in_error_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall cycle performance counter.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Memory-wait FSM with timeout and hazard watchdog.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= {WAIT_W{1'b0}};
      haz_cnt_q  <= {HAZ_W{1'b0}};
      timeout_q  <= 1'b0;
    end else begin
      haz_cnt_q <= haz_cnt_d;
      case (state_q)
        ST_RUN: begin
          if (freeze_s) begin
            state_q    <= ST_MEM_WAIT;
            wait_cnt_q <= WAIT_W'(1);
          end else if (haz_trip_s) begin
            state_q   <= ST_ERROR;
            timeout_q <= 1'b1;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (wait_trip_s) begin
            state_q   <= ST_ERROR;
            timeout_q <= 1'b1;
          end else if (freeze_s) begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end else if (haz_trip_s) begin
            state_q    <= ST_ERROR;
            wait_cnt_q <= {WAIT_W{1'b0}};
            timeout_q  <= 1'b1;
          end else begin
            state_q    <= ST_RUN;
            wait_cnt_q <= {WAIT_W{1'b0}};
          end
        end
        ST_ERROR: begin
          state_q   <= ST_ERROR;
          timeout_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_ERROR;
          timeout_q <= 1'b1;
        end
      endcase
    end
  end

  assign state_o        = state_q;
  assign stall_cycles_o = stall_cnt_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Randomized + directed bench for pipeline_control_unit against a
// cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_control_unit;

  localparam int MEM_TIMEOUT = 16;
  localparam int HAZARD_MAX  = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             hazard_detected_i = 1'b0;
  logic             branch_taken_i = 1'b0;
  logic             dmem_req_i = 1'b0;
  logic             dmem_ack_i = 1'b0;
  logic             pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
  logic             if_id_flush_o, id_ex_flush_o, mem_wb_flush_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cycles_o;
  logic             timeout_o;

  pipeline_control_unit #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .HAZARD_MAX (HAZARD_MAX),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .hazard_detected_i(hazard_detected_i),
    .branch_taken_i   (branch_taken_i),
    .dmem_req_i       (dmem_req_i),
    .dmem_ack_i       (dmem_ack_i),
    .pc_en_o          (pc_en_o),
    .if_id_en_o       (if_id_en_o),
    .id_ex_en_o       (id_ex_en_o),
    .ex_mem_en_o      (ex_mem_en_o),
    .mem_wb_en_o      (mem_wb_en_o),
    .if_id_flush_o    (if_id_flush_o),
    .id_ex_flush_o    (id_ex_flush_o),
    .mem_wb_flush_o   (mem_wb_flush_o),
    .state_o          (state_o),
    .stall_cycles_o   (stall_cycles_o),
    .timeout_o        (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: error flag, waiting flag, length of current wait, hazard run, stalls.
  bit m_known = 1'b0;
  bit m_err   = 1'b0;
  bit m_wait  = 1'b0;
  int m_wlen  = 0;
  int m_hrun  = 0;
  int m_stall = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input bit rst, input bit haz, input bit br, input bit req, input bit ack);
    logic [4:0] exp_en;
    logic [2:0] exp_fl;
    bit frozen;
    @(negedge clk_i);
    if (m_known) begin
      check_eq("state", {30'd0, state_o}, m_err ? 32'd2 : (m_wait ? 32'd1 : 32'd0));
      check_eq("stalls", {28'd0, stall_cycles_o}, m_stall);
      check_eq("timeout", {31'd0, timeout_o}, {31'd0, m_err});
    end
    rst_n_i = rst; hazard_detected_i = haz; branch_taken_i = br;
    dmem_req_i = req; dmem_ack_i = ack;
    #1;
    frozen = !ack && (m_wait || req);
    if (!rst)                 begin exp_en = 5'b00000; exp_fl = 3'b111; end
    else if (!m_known)        begin exp_en = {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o};
                                    exp_fl = {if_id_flush_o, id_ex_flush_o, mem_wb_flush_o}; end
    else if (m_err)           begin exp_en = 5'b00000; exp_fl = 3'b000; end
    else if (frozen)          begin exp_en = 5'b00000; exp_fl = 3'b001; end
    else if (br)              begin exp_en = 5'b11111; exp_fl = 3'b110; end
    else if (haz)             begin exp_en = 5'b00111; exp_fl = 3'b010; end
    else                      begin exp_en = 5'b11111; exp_fl = 3'b000; end
    if (!rst || m_known) begin
      check_eq("enables", {27'd0, pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o}, {27'd0, exp_en});
      check_eq("flushes", {29'd0, if_id_flush_o, id_ex_flush_o, mem_wb_flush_o}, {29'd0, exp_fl});
    end
    if (!rst) begin
      m_known = 1'b1; m_err = 1'b0; m_wait = 1'b0;
      m_wlen = 0; m_hrun = 0; m_stall = 0;
    end else if (m_known && !m_err) begin
      if ((frozen || (haz && !br)) && m_stall < CNT_MAX) m_stall++;
      if (frozen) begin
        m_wlen = m_wait ? m_wlen + 1 : 1;
        m_wait = 1'b1;
        if (m_wlen == MEM_TIMEOUT) m_err = 1'b1;
      end else begin
        m_wait = 1'b0;
        m_wlen = 0;
        if (haz && !br) begin
          m_hrun++;
          if (m_hrun == HAZARD_MAX) m_err = 1'b1;
        end else begin
          m_hrun = 0;
        end
      end
    end
  endtask

  // Constant expectations from the test plan, taken just after the next edge.
  task automatic expect_regs(input string tag, input int st, input int stalls, input int to);
    @(posedge clk_i);
    #1;
    check_eq({tag, "_state"}, {30'd0, state_o}, st);
    check_eq({tag, "_stalls"}, {28'd0, stall_cycles_o}, stalls);
    check_eq({tag, "_timeout"}, {31'd0, timeout_o}, to);
  endtask

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_regs("idle", 0, 0, 0);

    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    expect_regs("haz2", 0, 2, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    expect_regs("haz_br", 0, 2, 0);

    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0);
    expect_regs("frz1", 1, 1, 0);
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 1);
    expect_regs("ack_br", 0, 3, 0);
    step(1, 0, 0, 1, 1);
    expect_regs("req_ack", 0, 3, 0);

    step(0, 0, 0, 0, 0);
    for (int i = 0; i < MEM_TIMEOUT; i++) step(1, 0, 0, 1, 0);
    expect_regs("mem_to", 2, CNT_MAX, 1);
    step(1, 0, 0, 1, 1);
    step(1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    expect_regs("rst_err", 0, 0, 0);

    for (int i = 0; i < HAZARD_MAX; i++) step(1, 1, 0, 0, 0);
    expect_regs("haz_to", 2, HAZARD_MAX, 1);

    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    expect_regs("sat", 0, CNT_MAX, 0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 24) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0));
    end
    step(1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
